// File: rtl/pipe_stall_resp_if.sv
// Hazard-stall handshake between the hazard detector (master) and the pipeline front end (slave).
// Stall/redirect statistics signals exist only when STALL_STATS_EN is defined.
interface pipe_stall_resp_if;
  logic        stall;
  logic [31:0] instr_f;
  logic        redirect;
  logic [31:0] npc;
  logic [31:0] pc_f;
  logic [31:0] ir_d;
  logic [31:0] pc8_d;
  logic [31:0] ir_e;
  logic [31:0] pc8_e;
  logic        bubble_e;
  logic        stall_err;
`ifdef STALL_STATS_EN
  logic [31:0] stall_total;
  logic [31:0] redirect_total;
`endif

  modport master (
    output stall, instr_f, redirect, npc,
`ifdef STALL_STATS_EN
    input  stall_total, redirect_total,
`endif
    input  pc_f, ir_d, pc8_d, ir_e, pc8_e, bubble_e, stall_err
  );

  modport slave (
    input  stall, instr_f, redirect, npc,
`ifdef STALL_STATS_EN
    output stall_total, redirect_total,
`endif
    output pc_f, ir_d, pc8_d, ir_e, pc8_e, bubble_e, stall_err
  );
endinterface

// File: rtl/pipe_stall_resp.sv
// Front-end stall responder: fetch PC, F/D and D/E registers, bubble injection, runaway-stall monitor.
// Optional macro STALL_STATS_EN adds saturating stall/redirect cycle counters.
//
// state | meaning
// RUN   | no stall in progress
// STALL | stall run of 1..MAX_STALL cycles so far
// ERR   | stall run exceeded MAX_STALL; stall_err latched
module pipe_stall_resp #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int          MAX_STALL = 3,
  parameter int          CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stall_resp_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX_STALL = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  logic [31:0]      r_pc_f;
  logic [31:0]      r_ir_d;
  logic [31:0]      r_pc8_d;
  logic [31:0]      r_ir_e;
  logic [31:0]      r_pc8_e;
  logic             r_bubble_e;
  logic             r_stall_err;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_pc_plus8;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_pc_plus4 = r_pc_f + 32'd4;
  assign w_pc_plus8 = r_pc_f + 32'd8;
  assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;

  // Stall has priority over redirect: a stalled D instruction cannot legally redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f     <= PC_RESET;
      r_ir_d     <= 32'h0;
      r_pc8_d    <= 32'h0;
      r_ir_e     <= 32'h0;
      r_pc8_e    <= 32'h0;
      r_bubble_e <= 1'b0;
    end else if (bus.stall) begin
      r_ir_e     <= 32'h0;
      r_pc8_e    <= 32'h0;
      r_bubble_e <= 1'b1;
    end else begin
      r_pc_f     <= bus.redirect ? bus.npc : w_pc_plus4;
      r_ir_d     <= bus.instr_f;
      r_pc8_d    <= w_pc_plus8;
      r_ir_e     <= r_ir_d;
      r_pc8_e    <= r_pc8_d;
      r_bubble_e <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_stall_err <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.stall) begin
            r_state <= STALL;
            r_cnt   <= CNT_ONE;
          end
        end
        STALL: begin
          if (bus.stall) begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == CNT_MAX_STALL) begin
              r_state     <= ERR;
              r_stall_err <= 1'b1;
            end
          end else begin
            r_state <= RUN;
            r_cnt   <= '0;
          end
        end
        ERR: begin
          if (bus.stall) begin
            r_cnt <= w_cnt_inc;
          end else begin
            r_state <= RUN;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] r_stall_total;
  logic [31:0] r_redirect_total;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_total    <= 32'h0;
      r_redirect_total <= 32'h0;
    end else begin
      if (bus.stall && (r_stall_total != 32'hFFFF_FFFF)) begin
        r_stall_total <= r_stall_total + 32'd1;
      end
      if (bus.redirect && !bus.stall && (r_redirect_total != 32'hFFFF_FFFF)) begin
        r_redirect_total <= r_redirect_total + 32'd1;
      end
    end
  end

  assign bus.stall_total    = r_stall_total;
  assign bus.redirect_total = r_redirect_total;
`endif

  assign bus.pc_f      = r_pc_f;
  assign bus.ir_d      = r_ir_d;
  assign bus.pc8_d     = r_pc8_d;
  assign bus.ir_e      = r_ir_e;
  assign bus.pc8_e     = r_pc8_e;
  assign bus.bubble_e  = r_bubble_e;
  assign bus.stall_err = r_stall_err;

endmodule

// File: tb/tb_pipe_stall_resp.sv
// Directed self-checking bench for pipe_stall_resp; expected values are hand-computed.
module tb_pipe_stall_resp;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pipe_stall_resp_if bus ();

  pipe_stall_resp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset        = 1'b1;
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    bus.npc      = 32'h0;
    bus.instr_f  = 32'h3401_0001;
    tick();
    tick();
    chk("rst_pc_f", bus.pc_f, 32'h3000);
    chk("rst_ir_d", bus.ir_d, 32'h0);
    chk("rst_ir_e", bus.ir_e, 32'h0);
    chk("rst_pc8_d", bus.pc8_d, 32'h0);
    chk("rst_pc8_e", bus.pc8_e, 32'h0);
    chk("rst_bubble", {31'h0, bus.bubble_e}, 32'h0);
    chk("rst_err", {31'h0, bus.stall_err}, 32'h0);

    // Plain advance
    reset = 1'b0;
    tick();
    chk("adv1_pc_f", bus.pc_f, 32'h3004);
    chk("adv1_ir_d", bus.ir_d, 32'h3401_0001);
    chk("adv1_pc8_d", bus.pc8_d, 32'h3008);
    tick();
    chk("adv2_pc_f", bus.pc_f, 32'h3008);
    chk("adv2_ir_e", bus.ir_e, 32'h3401_0001);
    chk("adv2_pc8_e", bus.pc8_e, 32'h3008);
    chk("adv2_pc8_d", bus.pc8_d, 32'h300C);
    tick();
    chk("adv3_pc_f", bus.pc_f, 32'h300C);

    // Load-use stall for one cycle
    bus.instr_f = 32'h0022_1820;
    tick();
    chk("pre_stall_pc", bus.pc_f, 32'h3010);
    chk("pre_stall_ir_d", bus.ir_d, 32'h0022_1820);
    bus.stall = 1'b1;
    bus.instr_f = 32'hDEAD_BEEF;
    tick();
    chk("stall_pc_hold", bus.pc_f, 32'h3010);
    chk("stall_ir_d_hold", bus.ir_d, 32'h0022_1820);
    chk("stall_pc8_d_hold", bus.pc8_d, 32'h3014);
    chk("stall_ir_e_nop", bus.ir_e, 32'h0);
    chk("stall_pc8_e", bus.pc8_e, 32'h0);
    chk("stall_bubble", {31'h0, bus.bubble_e}, 32'h1);
    bus.stall = 1'b0;
    bus.instr_f = 32'h1000_0003;
    tick();
    chk("rel_ir_e", bus.ir_e, 32'h0022_1820);
    chk("rel_pc8_e", bus.pc8_e, 32'h3014);
    chk("rel_bubble", {31'h0, bus.bubble_e}, 32'h0);
    chk("rel_pc_f", bus.pc_f, 32'h3014);

    // Redirect keeps the delay slot
    bus.redirect = 1'b1;
    bus.npc = 32'h3040;
    bus.instr_f = 32'hAAAA_0001;
    tick();
    chk("redir_pc_f", bus.pc_f, 32'h3040);
    chk("redir_delay_slot", bus.ir_d, 32'hAAAA_0001);
    chk("redir_pc8_d", bus.pc8_d, 32'h301C);

    // Stall together with redirect: stall wins
    bus.stall = 1'b1;
    bus.npc = 32'h4000;
    bus.instr_f = 32'hBBBB_0002;
    tick();
    chk("stredir_pc_hold", bus.pc_f, 32'h3040);
    chk("stredir_ir_d_hold", bus.ir_d, 32'hAAAA_0001);
    chk("stredir_bubble", {31'h0, bus.bubble_e}, 32'h1);
    bus.stall = 1'b0;
    bus.instr_f = 32'h2402_0002;
    tick();
    chk("redir2_pc_f", bus.pc_f, 32'h4000);
    chk("redir2_ir_d", bus.ir_d, 32'h2402_0002);
    bus.redirect = 1'b0;

    // Exactly MAX_STALL cycles: no error
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("st3_err_%0d", i), {31'h0, bus.stall_err}, 32'h0);
    end
    bus.stall = 1'b0;
    tick();
    chk("st3_after_err", {31'h0, bus.stall_err}, 32'h0);
    chk("st3_after_pc", bus.pc_f, 32'h4004);
`ifdef STALL_STATS_EN
    chk("stats_stall_total", bus.stall_total, 32'd5);
    chk("stats_redirect_total", bus.redirect_total, 32'd2);
`endif

    // MAX_STALL+1 cycles: error latches on the 4th
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("st4_pre_err_%0d", i), {31'h0, bus.stall_err}, 32'h0);
    end
    tick();
    chk("st4_err_set", {31'h0, bus.stall_err}, 32'h1);
    chk("st4_pc_hold", bus.pc_f, 32'h4004);
    bus.stall = 1'b0;
    tick();
    chk("st4_err_sticky1", {31'h0, bus.stall_err}, 32'h1);
    chk("st4_pc_adv", bus.pc_f, 32'h4008);
    tick();
    chk("st4_err_sticky2", {31'h0, bus.stall_err}, 32'h1);

    // Reset mid-stall clears everything
    bus.stall = 1'b1;
    tick();
    reset = 1'b1;
    bus.redirect = 1'b1;
    bus.npc = 32'h5000;
    tick();
    chk("mrst_err", {31'h0, bus.stall_err}, 32'h0);
    chk("mrst_pc_f", bus.pc_f, 32'h3000);
    chk("mrst_ir_d", bus.ir_d, 32'h0);
    chk("mrst_ir_e", bus.ir_e, 32'h0);
    chk("mrst_bubble", {31'h0, bus.bubble_e}, 32'h0);
`ifdef STALL_STATS_EN
    chk("mrst_stall_total", bus.stall_total, 32'd0);
    chk("mrst_redirect_total", bus.redirect_total, 32'd0);
`endif

    // Fetch PC wrap
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b1;
    bus.npc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_setup_pc", bus.pc_f, 32'hFFFF_FFFC);
    chk("wrap_setup_pc8_d", bus.pc8_d, 32'h3008);
    bus.redirect = 1'b0;
    tick();
    chk("wrap_pc_f", bus.pc_f, 32'h0);
    chk("wrap_pc8_d", bus.pc8_d, 32'h4);
    chk("wrap_err_clear", {31'h0, bus.stall_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stall_resp.md
Name: pipe_stall_resp

Overview:
- Responder side of the hazard-stall interface. It consumes the one-bit stall request from the hazard detector and applies it to the front of the 5-stage MIPS pipeline.
- Owns the fetch PC register, the F/D pipeline register (IR_D, PC8_D) and the D/E pipeline register (IR_E, PC8_E).
- On stall it freezes PC and F/D and injects a nop bubble into D/E. Otherwise it advances the pipeline and applies branch/jump redirects with a delay slot.
- Also tracks consecutive stall cycles and flags runaway stalls.

Parameters:
- PC_RESET, 32'h00003000, fetch PC after reset.
- MAX_STALL, 3, largest legal run of consecutive stall cycles; longer runs raise stall_err.
- CNT_W, 4, width of the consecutive-stall counter; must satisfy 2^CNT_W > MAX_STALL+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  stall request from hazard detector (combinational, same cycle)
- instr_f  in  32  instruction read from IM at pc_f
- redirect  in  1  branch taken / j / jal / jr resolved in D this cycle
- npc  in  32  redirect target, valid when redirect=1
- pc_f  out  32  current fetch PC
- ir_d  out  32  F/D instruction register
- pc8_d  out  32  F/D PC+8 (link value)
- ir_e  out  32  D/E instruction register
- pc8_e  out  32  D/E PC+8
- bubble_e  out  1  1 when ir_e holds an injected bubble
- stall_err  out  1  sticky: stall lasted more than MAX_STALL consecutive cycles

Behaviour:
- Reset (sync, reset=1 at posedge):
  - pc_f=PC_RESET
  - ir_d=ir_e=32'h0 (sll $0 = nop)
  - pc8_d=pc8_e=0, bubble_e=0, stall_err=0
  - counter=0, FSM=RUN
  - reset overrides stall/redirect in the same cycle.
- Normal advance (stall=0):
  - pc_f <= redirect ? npc : pc_f+4 (32-bit, wraps modulo 2^32)
  - ir_d <= instr_f, pc8_d <= pc_f+8
  - ir_e <= ir_d, pc8_e <= pc8_d, bubble_e <= 0
  - redirect does NOT flush ir_d: the delay-slot instruction always proceeds.
- Stall (stall=1):
  - pc_f, ir_d, pc8_d hold.
  - ir_e <= 0, pc8_e <= 0, bubble_e <= 1.
  - redirect is ignored. A stalled D instruction cannot legally redirect, so stall has priority.
- Latency: a stall request affects registers at the next posedge; ir_e shows the bubble one cycle after stall is sampled.
- FSM states:
  - RUN: stall=0 holds in RUN; stall=1 goes to STALL with counter=1.
  - STALL: stall=1 increments counter, saturating at 2^CNT_W-1; stall=0 returns to RUN and clears counter.
  - ERR: entered from STALL when stall=1 and counter==MAX_STALL, i.e. at the (MAX_STALL+1)th consecutive stall cycle. stall_err <= 1, sticky until reset. In ERR, stall handling continues identically; stall=0 returns to RUN without clearing stall_err.
- Boundary cases:
  - stall and redirect together: stall wins, PC holds.
  - A back-to-back stall run of exactly MAX_STALL cycles does not set stall_err.
  - pc_f=32'hFFFFFFFC with no redirect wraps to 0.
  - Reset asserted mid-stall clears everything, including stall_err; pipeline restarts from PC_RESET.

Optional Feature:
- Macro STALL_STATS_EN.
- Defined: adds outputs stall_total[31:0] and redirect_total[31:0].
  - stall_total counts every cycle with stall=1.
  - redirect_total counts cycles with redirect=1 and stall=0.
  - Both clear on reset and saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is unchanged.

Test Plan:
- Release reset, stall=0, redirect=0, instr_f=32'h34010001 for 3 cycles -> pc_f 3000→3004→3008→300C; ir_d=34010001 after cycle 1; ir_e=34010001 after cycle 2; pc8_d=32'h3008 after cycle 1.
- ir_d=lw-dependent instr, stall=1 for 1 cycle -> pc_f and ir_d unchanged; ir_e=0, bubble_e=1, pc8_e=0 next cycle; on release ir_e=ir_d, bubble_e=0.
- redirect=1, npc=32'h00003040, stall=0 at pc_f=32'h3010 -> next pc_f=32'h3040; ir_d=instr_f fetched at 3010 (delay slot kept).
- stall=1 and redirect=1, npc=32'h4000 simultaneously -> pc_f holds; the redirect is applied only when it is presented again with stall=0.
- stall=1 for exactly MAX_STALL (3) cycles -> stall_err=0; then stall=1 for 4 consecutive cycles -> stall_err=1 after the 4th, stays 1 after stall=0, clears only on reset.
- With STALL_STATS_EN: 5 stall cycles plus 2 redirects -> stall_total=5, redirect_total=2; reset -> both 0.
